// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec_pkg
// Purpose  : Shared vector-unit constants and writeback entry types.
// Revision : 1.0  initial release
// ============================================================================
package vec_pkg;

  localparam int VLEN       = 512;
  localparam int VREG_TAG_W = 5;

  typedef logic [VREG_TAG_W-1:0] vreg_tag_t;

  typedef struct packed {
    vreg_tag_t        tag;
    logic [VLEN-1:0]  data;
  } vwb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wbq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wbq_fifo
// Purpose  : Width/depth parameterised synchronous FIFO, async active-high
//            reset, exposing count/full/empty. Caller guards push and pop.
// Revision : 1.0  initial release
// ============================================================================
module wbq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int           c_AW      = $clog2(DEPTH);
  localparam int           c_CNT_W   = $clog2(DEPTH+1);
  localparam logic [c_AW:0] c_PTR_ONE = (c_AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  // Storage needs no reset: reads are qualified by empty in the parent.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
  end

  assign head_data = r_mem[r_rd_ptr[c_AW-1:0]];
  assign count     = c_CNT_W'(r_wr_ptr - r_rd_ptr);
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/vector_fma_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : vector_fma_wb_queue
// Purpose  : Pairs issue-time destination tags with fixed-latency FMA results
//            and buffers them for the VRF write port; throttles issue so every
//            in-flight op owns a slot. Option: VFMA_WBQ_BYPASS_EN.
// Revision : 1.0  initial release
// ============================================================================
module vector_fma_wb_queue
  import vec_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iss_valid_i,
  input  logic [TAG_W-1:0]           iss_vd_i,
  output logic                       iss_ready_o,
  input  logic                       fma_valid_i,
  input  logic [VLEN-1:0]            fma_result_i,
  output logic                       wb_valid_o,
  output logic [TAG_W-1:0]           wb_vd_o,
  output logic [VLEN-1:0]            wb_data_o,
  input  logic                       wb_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic                       overflow_o
);

  localparam int                 c_CNT_W = $clog2(DEPTH+1);
  localparam int                 c_ENT_W = TAG_W + VLEN;
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(DEPTH);

  logic [c_CNT_W-1:0] r_pend;
  logic               r_overflow;

  logic               w_iss_acc;
  logic               w_wb_fire;
  logic               w_tag_push;
  logic               w_tag_pop;
  logic [TAG_W-1:0]   w_tag_head;
  logic [TAG_W-1:0]   w_res_tag;
  logic [c_CNT_W-1:0] w_tag_count;
  logic               w_tag_full;
  logic               w_tag_empty;

  logic               w_dq_push;
  logic               w_dq_pop;
  logic [c_ENT_W-1:0] w_dq_push_data;
  logic [c_ENT_W-1:0] w_dq_head;
  logic [c_CNT_W-1:0] w_dq_count;
  logic               w_dq_full;
  logic               w_dq_empty;
  logic               w_unused;

  // Ready looks only at the registered count; no path from wb_ready_i.
  assign iss_ready_o = (r_pend < c_LIMIT);
  assign w_iss_acc   = iss_valid_i && iss_ready_o;
  assign w_tag_push  = w_iss_acc && !w_tag_full;
  assign w_tag_pop   = fma_valid_i && !w_tag_empty;
  assign w_res_tag   = w_tag_empty ? '0 : w_tag_head;

  assign w_dq_push_data = {w_res_tag, fma_result_i};
  assign w_wb_fire      = wb_valid_o && wb_ready_i;
  assign w_dq_pop       = w_wb_fire && !w_dq_empty;

`ifdef VFMA_WBQ_BYPASS_EN
  logic w_bypass;
  assign w_bypass   = w_dq_empty && fma_valid_i;
  assign wb_valid_o = !w_dq_empty || fma_valid_i;
  assign {wb_vd_o, wb_data_o} = !w_dq_empty ? w_dq_head :
                                (fma_valid_i ? w_dq_push_data : '0);
  assign w_dq_push  = fma_valid_i && !(w_bypass && wb_ready_i) &&
                      (!w_dq_full || w_dq_pop);
`else
  assign wb_valid_o = !w_dq_empty;
  assign {wb_vd_o, wb_data_o} = w_dq_empty ? '0 : w_dq_head;
  assign w_dq_push  = fma_valid_i && (!w_dq_full || w_dq_pop);
`endif

  assign occupancy_o = r_pend;
  assign overflow_o  = r_overflow;
  assign w_unused    = ^{w_tag_count, w_dq_count};

  wbq_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_tag_push),
    .push_data (iss_vd_i),
    .pop       (w_tag_pop),
    .head_data (w_tag_head),
    .count     (w_tag_count),
    .full      (w_tag_full),
    .empty     (w_tag_empty)
  );

  wbq_fifo #(
    .WIDTH (c_ENT_W),
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_dq_push),
    .push_data (w_dq_push_data),
    .pop       (w_dq_pop),
    .head_data (w_dq_head),
    .count     (w_dq_count),
    .full      (w_dq_full),
    .empty     (w_dq_empty)
  );

  // Orphan results (protocol error) can drain without a matching issue,
  // so the decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_iss_acc && !w_wb_fire)
        r_pend <= r_pend + c_ONE;
      else if (!w_iss_acc && w_wb_fire && (r_pend != '0))
        r_pend <= r_pend - c_ONE;
      if (fma_valid_i && w_tag_empty)
        r_overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vector_fma_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_fma_wb_queue
// Purpose  : Directed self-checking bench with a 5-cycle FMA model and an
//            in-order writeback scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_vector_fma_wb_queue;

  localparam int DEPTH = 8;
  localparam int TAG_W = 5;
  localparam int VLEN  = 512;
  localparam int LAT   = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             iss_valid_i = 1'b0;
  logic [TAG_W-1:0] iss_vd_i = '0;
  logic             iss_ready_o;
  logic             fma_valid_i = 1'b0;
  logic [VLEN-1:0]  fma_result_i = '0;
  logic             wb_valid_o;
  logic [TAG_W-1:0] wb_vd_o;
  logic [VLEN-1:0]  wb_data_o;
  logic             wb_ready_i = 1'b0;
  logic [3:0]       occupancy_o;
  logic             overflow_o;

  always #5 clk = ~clk;

  vector_fma_wb_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .iss_valid_i  (iss_valid_i),
    .iss_vd_i     (iss_vd_i),
    .iss_ready_o  (iss_ready_o),
    .fma_valid_i  (fma_valid_i),
    .fma_result_i (fma_result_i),
    .wb_valid_o   (wb_valid_o),
    .wb_vd_o      (wb_vd_o),
    .wb_data_o    (wb_data_o),
    .wb_ready_i   (wb_ready_i),
    .occupancy_o  (occupancy_o),
    .overflow_o   (overflow_o)
  );

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [VLEN-1:0]  data;
  } ent_t;

  ent_t             sbq[$];
  logic [TAG_W-1:0] tagq[$];
  logic             pipe_v [LAT];
  logic [VLEN-1:0]  pipe_d [LAT];
  int               exp_pend = 0;
  logic             exp_ovf  = 1'b0;
  logic             inj_fma  = 1'b0;
  logic [VLEN-1:0]  inj_data = '0;
  int               op_n  = 0;
  int               n_cmp = 0;
  int               n_bad = 0;

  function automatic logic [VLEN-1:0] mk_data(input int n);
    logic [31:0] w;
    w = 32'hA5A5A5A5 ^ (32'(n) * 32'h01010101);
    return {16{w}};
  endfunction

  task automatic chk(input string tag, input logic [VLEN+TAG_W-1:0] obs,
                     input logic [VLEN+TAG_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    sbq.delete();
    tagq.delete();
    for (int i = 0; i < LAT; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = '0;
    end
    exp_pend = 0;
    exp_ovf  = 1'b0;
  endtask

  // One clock: drive FMA model output, check outputs, update model, advance.
  task automatic cycle();
    logic acc, wbf;
    ent_t e;
    fma_valid_i  = pipe_v[LAT-1] | inj_fma;
    fma_result_i = inj_fma ? inj_data : pipe_d[LAT-1];
    #1;
    chk("iss_ready", iss_ready_o, exp_pend < DEPTH);
    chk("occupancy", occupancy_o, exp_pend);
    chk("overflow",  overflow_o,  exp_ovf);
    chk("wb_valid",  wb_valid_o,  sbq.size() != 0);
    acc = iss_valid_i && (exp_pend < DEPTH);
    wbf = wb_valid_o && wb_ready_i;
    if (wbf && sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("wb_vd",   wb_vd_o,   e.tag);
      chk("wb_data", wb_data_o, e.data);
    end
    if (fma_valid_i) begin
      if (tagq.size() == 0) begin
        exp_ovf = 1'b1;
        e.tag   = '0;
      end else begin
        e.tag = tagq.pop_front();
      end
      e.data = fma_result_i;
      if (sbq.size() < DEPTH) sbq.push_back(e);
    end
    if (acc) tagq.push_back(iss_vd_i);
    if (acc && !wbf) exp_pend++;
    else if (!acc && wbf && exp_pend > 0) exp_pend--;
    for (int i = LAT-1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_d[i] = pipe_d[i-1];
    end
    pipe_v[0] = acc;
    pipe_d[0] = mk_data(op_n);
    if (acc) op_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_iss_ready"}, iss_ready_o, 1);
    chk({pfx, "_wb_valid"},  wb_valid_o,  0);
    chk({pfx, "_wb_vd"},     wb_vd_o,     0);
    chk({pfx, "_wb_data"},   wb_data_o,   0);
    chk({pfx, "_occupancy"}, occupancy_o, 0);
    chk({pfx, "_overflow"},  overflow_o,  0);
  endtask

  initial begin
    clear_model();
    #1;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single op: issue tag 7, result 5 cycles later, writeback one after that.
    wb_ready_i  = 1'b1;
    iss_valid_i = 1'b1;
    iss_vd_i    = 5'd7;
    cycle();
    iss_valid_i = 1'b0;
    for (int i = 0; i < LAT; i++) cycle();
    chk("single_wb_valid", wb_valid_o, 1);
    chk("single_wb_vd",    wb_vd_o,    7);
    chk("single_wb_data",  wb_data_o,  {16{32'hA5A5A5A5}});
    cycle();
    chk("single_occ_zero", occupancy_o, 0);

    // Fill to limit with writeback blocked.
    wb_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      iss_valid_i = 1'b1;
      iss_vd_i    = TAG_W'(i);
      cycle();
    end
    chk("fill_iss_ready_low", iss_ready_o, 0);
    iss_vd_i = 5'd9;
    cycle();
    iss_valid_i = 1'b0;
    chk("fill_occ_8", occupancy_o, 8);
    for (int i = 0; i < 6; i++) cycle();

    // At pend=8: writeback and issue together; issue must be rejected.
    wb_ready_i  = 1'b1;
    iss_valid_i = 1'b1;
    iss_vd_i    = 5'd20;
    cycle();
    iss_valid_i = 1'b0;
    chk("drain_occ_7",        occupancy_o, 7);
    chk("drain_ready_reasrt", iss_ready_o, 1);
    for (int i = 0; i < DEPTH-1; i++) cycle();
    chk("drain_occ_0", occupancy_o, 0);

    // pend=5 with issue, FMA result and writeback all in one cycle.
    wb_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iss_valid_i = 1'b1;
      iss_vd_i    = TAG_W'(10 + i);
      cycle();
    end
    iss_valid_i = 1'b0;
    cycle();
    iss_valid_i = 1'b1;
    iss_vd_i    = 5'd15;
    wb_ready_i  = 1'b1;
    cycle();
    iss_valid_i = 1'b0;
    chk("triple_occ_5", occupancy_o, 5);
    for (int i = 0; i < 12; i++) cycle();

    // Protocol error: a result with nothing issued.
    inj_fma  = 1'b1;
    inj_data = {16{32'hDEADBEEF}};
    cycle();
    inj_fma = 1'b0;
    chk("ovf_set", overflow_o, 1);
    iss_valid_i = 1'b1;
    iss_vd_i    = 5'd3;
    cycle();
    iss_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    chk("ovf_sticky", overflow_o, 1);

    // Mid-operation reset with 3 ops pending, two of them buffered.
    wb_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iss_valid_i = 1'b1;
      iss_vd_i    = TAG_W'(20 + i);
      cycle();
    end
    iss_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("pre_rst_occ_3", occupancy_o, 3);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    clear_model();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    wb_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
